// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle WIDTH-bit shifter/rotator, one bit position per clock
//
// Purpose: parametrised state register with load, clear, logical/arithmetic
// shift, rotate and serial-insert modes under a start/busy/done handshake.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset
//   start in   1      request, accepted in IDLE or DONE
//   op    in   3      LOAD/SLL/SRL/SRA/ROL/ROR/SLI/CLR
//   din   in   WIDTH  operand, captured at an accepted start
//   amt   in   SHW    shift count, captured at an accepted start
//   sin   in   1      serial input for SLI, sampled every SHIFT cycle
//   dout  out  WIDTH  data register
//   sout  out  1      last bit shifted or rotated out
//   busy  out  1      high while shifting
//   done  out  1      one-cycle completion pulse
//   zero  out  1      dout == 0 (combinational)

module seq_shifter #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SLI  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             sout_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [2:0]       op_q, op_nxt;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dout  <= '0;
      sout  <= 1'b0;
      cnt   <= '0;
      op_q  <= OP_LOAD;
    end else begin
      state <= state_nxt;
      dout  <= dout_nxt;
      sout  <= sout_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dout_nxt  = dout;
    sout_nxt  = sout;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    // Requests arriving while shifting are dropped, not queued.
    accept    = start && (state != SHIFT);

    case (state)
      SHIFT: begin
        case (op_q)
          OP_SLL: begin
            dout_nxt = {dout[WIDTH-2:0], 1'b0};
            sout_nxt = dout[WIDTH-1];
          end
          OP_SRL: begin
            dout_nxt = {1'b0, dout[WIDTH-1:1]};
            sout_nxt = dout[0];
          end
          OP_SRA: begin
            dout_nxt = {dout[WIDTH-1], dout[WIDTH-1:1]};
            sout_nxt = dout[0];
          end
          OP_ROL: begin
            dout_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
            sout_nxt = dout[WIDTH-1];
          end
          OP_ROR: begin
            dout_nxt = {dout[0], dout[WIDTH-1:1]};
            sout_nxt = dout[0];
          end
          OP_SLI: begin
            dout_nxt = {dout[WIDTH-2:0], sin};
            sout_nxt = dout[WIDTH-1];
          end
          default: begin
            dout_nxt = dout;
            sout_nxt = sout;
          end
        endcase
        cnt_nxt   = cnt - SHW'(1);
        state_nxt = (cnt == SHW'(1)) ? DONE : SHIFT;
      end

      default: begin
        // IDLE and DONE behave alike: DONE falls back to IDLE unless a new
        // request is accepted in the same cycle.
        state_nxt = IDLE;
        if (accept) begin
          op_nxt  = op;
          cnt_nxt = amt;
          if (op == OP_CLR) begin
            dout_nxt  = '0;
            sout_nxt  = 1'b0;
            state_nxt = DONE;
          end else if (op == OP_LOAD) begin
            dout_nxt  = din;
            sout_nxt  = 1'b0;
            state_nxt = DONE;
          end else begin
            // Zero-length shift completes immediately and keeps sout.
            dout_nxt  = din;
            state_nxt = (amt == '0) ? DONE : SHIFT;
          end
        end
      end
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign zero = (dout == '0);

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, multi-cycle sequential shifter/rotator that extends the single-bit reset flip-flop into a WIDTH-bit register with load, clear, logical/arithmetic shift, rotate and serial-insert modes. The block performs one bit-position of shift per clock under a start/busy/done handshake. It serves the datapath as a low-area shift unit and as a general-purpose parametrised state register.

## Interface
- WIDTH, default 16: data width in bits. Must be at least 2.
- SHW, derived localparam, equal to $clog2(WIDTH): width of the shift amount.

- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Sampled only when not busy.
- op  in  3  operation code:
  - 000: LOAD
  - 001: SLL
  - 010: SRL
  - 011: SRA
  - 100: ROL
  - 101: ROR
  - 110: SLI (shift left, insert sin)
  - 111: CLR
- din  in  WIDTH  operand, captured at an accepted start.
- amt  in  SHW  shift count, 0 to WIDTH-1, captured at an accepted start.
- sin  in  1  serial input for SLI, sampled every SHIFT cycle.
- dout  out  WIDTH  data register.
- sout  out  1  last bit shifted or rotated out.
- busy  out  1  high while in the SHIFT state.
- done  out  1  one-cycle completion pulse.
- zero  out  1  combinational, dout == 0.

## Operation
- FSM states:
  - IDLE -> SHIFT on an accepted start when op is a shift/rotate and amt != 0.
  - IDLE -> DONE on an accepted start when op is LOAD, op is CLR, or amt == 0.
  - SHIFT -> SHIFT while cnt > 1.
  - SHIFT -> DONE when cnt == 1.
  - DONE -> IDLE, or DONE -> SHIFT/DONE if start is high in DONE (back-to-back request accepted).
- Accept rule: start is accepted in IDLE or DONE. Start while busy is ignored, and op, din and amt changes are ignored while busy.
- At acceptance:
  - dout <= din (CLR: dout <= 0).
  - cnt <= amt, op latched.
  - LOAD and CLR ignore amt and clear sout.
  - For a shift/rotate with amt == 0, dout <= din and sout is held.
- Each SHIFT cycle (one position per cycle, on the latched op):
  - SLL: dout <= {dout[W-2:0],0}, sout <= dout[W-1].
  - SRL: dout <= {0,dout[W-1:1]}, sout <= dout[0].
  - SRA: dout <= {dout[W-1],dout[W-1:1]}, sout <= dout[0].
  - ROL: dout <= {dout[W-2:0],dout[W-1]}, sout <= dout[W-1].
  - ROR: dout <= {dout[0],dout[W-1:1]}, sout <= dout[0].
  - SLI: dout <= {dout[W-2:0],sin}, sout <= dout[W-1].
  - cnt <= cnt-1.
- Result holding: dout and sout hold their final values after DONE until the next accepted start.
- Reset (any time, including mid-SHIFT): abort with no done pulse.
  - State IDLE, cnt 0.
  - dout 0, sout 0, busy 0, done 0, hence zero 1.

## Timing
- Start accepted at rising edge k.
- Shift/rotate with amt = n ≥ 1:
  - busy is high for cycles k+1 .. k+n.
  - done is high for cycle k+n+1 only.
  - dout is final from cycle k+n+1.
- LOAD, CLR, or amt = 0: done is high in cycle k+1, and busy never rises.
- Back-to-back: a start during the DONE cycle is accepted at that edge. done drops next cycle unless the new op also completes immediately, in which case done stays high.
- busy and done are registered outputs, decoded from state. zero is combinational from dout.
- sout updates on the same edge as dout.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> immediately dout=0x0000, sout=0, busy=0, done=0, zero=1.
- SLL, WIDTH=16: din=0x0001, amt=4 -> busy 4 cycles, then done pulse in cycle k+5, dout=0x0010, sout=0.
- SRA: din=0x8000, amt=15 -> 15 busy cycles, then dout=0xFFFF, sout=0.
- ROR: din=0x0001, amt=1 -> done at k+2, dout=0x8000, sout=1. Then a back-to-back start in the DONE cycle with LOAD din=0x1234, amt=5 -> done again in the next cycle, dout=0x1234, sout=0.
- SLI with sin held 1: din=0x0000, amt=3 -> dout=0x0007. The same SLI with a second start pulsed during busy (op=CLR) -> ignored, result still 0x0007.
- Abort: SLL din=0xFFFF, amt=8, assert rst in the third busy cycle -> dout=0, busy=0, no done pulse. Then CLR after release -> done at k+1, zero=1.
